// File: rtl/clkdiv_pkg.sv
// Shared defaults and helpers for the clkdiv_bank divider channels.
// Optional tick outputs are enabled with CLKDIV_TICK_EN.
package clkdiv_pkg;

  localparam int DEF_CNT_W    = 16;
  localparam int DEF_HALF_RST = 2500;

  // Width of a channel index; a single channel still needs one select bit.
  function automatic int chan_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A zero half-period would never wrap, so it is treated as one cycle.
  function automatic logic [31:0] clamp_half(input logic [31:0] h);
    return (h == 32'd0) ? 32'd1 : h;
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: half-period counter, active/pending reload, slw and tick.
// Tick register exists only when CLKDIV_TICK_EN is defined; otherwise tick is 0.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int HALF_RST = DEF_HALF_RST
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] half,
  output logic             pend,
  output logic             slw,
  output logic             tick
);

  localparam logic [CNT_W-1:0] HALF_INIT = CNT_W'(clamp_half(32'(HALF_RST)));

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active;
  logic [CNT_W-1:0] pending;
  logic             wrap;

  assign wrap = en && (cnt == active - 1'b1);

  // A pending value is only swapped in at a wrap or while idle, so a running
  // square wave never sees a shortened half-period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      active  <= HALF_INIT;
      pending <= HALF_INIT;
      pend    <= 1'b0;
      slw     <= 1'b0;
    end else begin
      if (wrap) begin
        cnt <= '0;
        slw <= ~slw;
      end else if (en) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end

      if (pend && (wrap || !en)) begin
        active <= pending;
        pend   <= 1'b0;
      end else if (wr) begin
        pending <= half;
        pend    <= 1'b1;
      end
    end
  end

`ifdef CLKDIV_TICK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick <= 1'b0;
    end else begin
      tick <= wrap;
    end
  end
`else
  assign tick = 1'b0;
`endif

endmodule

// File: rtl/clkdiv_bank.sv
// Bank of independent clock-enable dividers with a shared valid/ready write port.
// Define CLKDIV_TICK_EN to build the per-channel tick strobes.
module clkdiv_bank
  import clkdiv_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int HALF_RST = DEF_HALF_RST,
  localparam int SEL_W   = chan_idx_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                wr_valid,
  input  logic [SEL_W-1:0]    wr_sel,
  input  logic [CNT_W-1:0]    half_in,
  output logic                wr_ready,
  output logic [CHANNELS-1:0] slw,
  output logic [CHANNELS-1:0] tick
);

  logic [CHANNELS-1:0]     pend;
  logic [(1<<SEL_W)-1:0]   pend_ext;
  logic [CNT_W-1:0]        half_clamped;
  logic                    wr_fire;

  // Unused select codes read as "not pending", so writes to them are accepted and dropped.
  always_comb begin
    pend_ext                 = '0;
    pend_ext[CHANNELS-1:0]   = pend;
  end

  assign wr_ready     = ~pend_ext[wr_sel];
  assign wr_fire      = wr_valid && wr_ready;
  assign half_clamped = CNT_W'(clamp_half(32'(half_in)));

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    clkdiv_chan #(
      .CNT_W    (CNT_W),
      .HALF_RST (HALF_RST)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .en   (en[i]),
      .wr   (wr_fire && (wr_sel == SEL_W'(i))),
      .half (half_clamped),
      .pend (pend[i]),
      .slw  (slw[i]),
      .tick (tick[i])
    );
  end

endmodule

// File: doc/clkdiv_bank.md
# clkdiv_bank

Parametrised bank of independent clock-enable generators, each producing a 50%-duty divided square wave and a one-cycle tick strobe from the single system clock. Each channel's half-period can be reprogrammed at run time through a valid/ready write port; new values take effect glitch-free at the channel's next wrap. Sits beside the system clock input and feeds slow-rate logic: display refresh, debouncers, audio sampling.

## Interface
- CHANNELS, 4: number of independent divider channels (1..16).
- CNT_W, 16: counter and half-period width in bits.
- HALF_RST, 2500: half-period loaded into every channel at reset (100 MHz → 20 kHz).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  CHANNELS  per-channel run enable.
- wr_valid  in  1  write request.
- wr_sel  in  max(1,$clog2(CHANNELS))  target channel index.
- half_in  in  CNT_W  requested half-period in clk cycles.
- wr_ready  out  1  write can be accepted this cycle (combinational).
- slw  out  CHANNELS  divided square waves (registered).
- tick  out  CHANNELS  one-cycle strobe coincident with each slw toggle (registered).

## Operation
- Per channel state: cnt[CNT_W], active half-period, pending half-period, pend flag, slw, tick.
- Reset: cnt=0, active=HALF_RST, pending=HALF_RST, pend=0, slw=0, tick=0; wr_ready therefore 1.
- en[i]=1: each edge, cnt==active-1 → cnt<=0, slw<=~slw, tick<=1, and if pend then active<=pending, pend<=0; otherwise cnt<=cnt+1, tick<=0.
- en[i]=0: cnt<=0, slw holds, tick<=0; if pend, active<=pending and pend<=0 on the next edge (immediate apply while idle).
- Write: handshake when wr_valid && wr_ready. pending[wr_sel]<=half_in, pend[wr_sel]<=1.
- wr_ready = ~pend[wr_sel] for a valid index; 1 for wr_sel ≥ CHANNELS (write accepted and discarded).
- half_in==0 is stored as 1 (toggle every enabled cycle).
- Write accepted in the same cycle as that channel's wrap with pend=0: stored, applied at the following wrap; the current wrap keeps the old active value.
- en deasserted mid-count: count discarded; on re-enable first toggle occurs after a full active half-period.
- rst asserted at any time: immediate return to reset values, pending writes lost.

## Timing
- Toggle/tick latency: after en rises (cnt=0), slw toggles and tick is high in the cycle following the active-th enabled edge.
- slw period = 2×active cycles; tick high exactly 1 cycle per active cycles.
- Write-to-effect: running channel, at its next wrap (≤ active cycles); idle channel, 1 edge after acceptance.
- wr_ready low from the edge after acceptance until the edge on which pending is applied.
- Channels fully independent; no cross-channel phase alignment.

## Configuration
- CLKDIV_TICK_EN defined: tick outputs driven as above.
- Not defined: tick registers removed, tick tied to all-zero; slw behaviour unchanged.

## Structure
- Package clkdiv_pkg: CNT_W and HALF_RST defaults, channel-index width function, zero-to-one half-period clamp function.
- Sub-module clkdiv_chan: one channel (counter, active/pending, slw, tick); top generates CHANNELS instances plus write decode and wr_ready mux.

## Test plan
- Reset, en=1, HALF_RST=2500 → ch0 first tick/toggle after 2500 edges, slw period 5000, tick every 2500 cycles.
- Running ch1 (active=10), write half_in=4 at cnt=3 → wr_ready low until wrap at cnt=9; subsequent intervals 4 cycles, no short or glitch interval.
- en[2]=0, write half_in=0 → applied next edge as 1, wr_ready returns 1; en[2]=1 → slw toggles every cycle.
- Write to ch3 in same cycle as its wrap → wrap uses old value, next interval uses new value.
- CHANNELS=3, wr_sel=3 → wr_ready=1, write dropped, all channels unchanged.
- rst pulse mid-count with pending write → all slw=0, tick=0, active=HALF_RST, wr_ready=1; CLKDIV_TICK_EN undefined build → tick constant 0.
